// File: rtl/sim_commit_monitor.sv
// Commit-stream monitor: cycle/instret counters, ebreak trap classification via a0,
// cycle-limit watchdog. Define SIM_MON_HIST_EN to build the committed-PC ring buffer.
module sim_commit_monitor #(
   parameter int              XLEN       = 32,
   parameter int              NCOMMIT    = 1,
   parameter int              CNT_W      = 32,
   parameter int              MAX_CYCLES = 1000000,
   parameter logic [XLEN-1:0] TRAP_INSTR = XLEN'(32'h00100073),
   parameter int              HIST_DEPTH = 16,
   localparam int             AW         = $clog2(HIST_DEPTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [NCOMMIT-1:0]      i_commit_valid,
   input  logic [NCOMMIT*XLEN-1:0] i_commit_pc,
   input  logic [NCOMMIT*XLEN-1:0] i_commit_instr,
   input  logic [XLEN-1:0]         i_trap_a0,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [2:0]              o_status,
   output logic [CNT_W-1:0]        o_cycle_cnt,
   output logic [CNT_W-1:0]        o_instr_cnt,
   output logic [XLEN-1:0]         o_trap_pc,
   input  logic [AW-1:0]           i_hist_rd_idx,
   output logic [XLEN-1:0]         o_hist_rd_pc,
   output logic [AW:0]             o_hist_count
);
   localparam logic [2:0] ST_NONE = 3'd0, ST_GOOD = 3'd1, ST_BAD = 3'd2,
                          ST_UNKNOWN = 3'd3, ST_TIMEOUT = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    r_state;
   logic                      r_busy, r_done;
   logic [2:0]                r_status;
   logic [CNT_W-1:0]          r_cycle_cnt, r_instr_cnt;
   logic [XLEN-1:0]           r_trap_pc;

   logic [NCOMMIT-1:0]        w_cnt_lane;
   logic [NCOMMIT-1:0][AW-1:0] w_rank;
   logic [2:0]                w_ncnt;
   logic                      w_trap_hit;
   logic [XLEN-1:0]           w_trap_pc;

   // Lanes are scanned oldest first; once a trap is seen the younger lanes are dropped.
   // w_rank is each lane's offset from the history write pointer.
   always_comb begin
      w_cnt_lane = '0;
      w_rank     = '0;
      w_ncnt     = '0;
      w_trap_hit = 1'b0;
      w_trap_pc  = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
         w_rank[i] = AW'(w_ncnt);
         if (i_commit_valid[i] && !w_trap_hit) begin
            w_cnt_lane[i] = 1'b1;
            w_ncnt        = w_ncnt + 3'd1;
            if (i_commit_instr[i*XLEN +: XLEN] == TRAP_INSTR) begin
               w_trap_hit = 1'b1;
               w_trap_pc  = i_commit_pc[i*XLEN +: XLEN];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_status    <= ST_NONE;
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
         r_trap_pc   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state     <= S_RUN;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_status    <= ST_NONE;
                  r_cycle_cnt <= '0;
                  r_instr_cnt <= '0;
                  r_trap_pc   <= '0;
               end
            end
            S_RUN: begin
               r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
               r_instr_cnt <= r_instr_cnt + CNT_W'(w_ncnt);
               if (w_trap_hit) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_trap_pc <= w_trap_pc;
                  if (i_trap_a0 == '0)             r_status <= ST_GOOD;
                  else if (i_trap_a0 == XLEN'(1))  r_status <= ST_BAD;
                  else                             r_status <= ST_UNKNOWN;
               end else if (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
                  r_state  <= S_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_status <= ST_TIMEOUT;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_status    = r_status;
   assign o_cycle_cnt = r_cycle_cnt;
   assign o_instr_cnt = r_instr_cnt;
   assign o_trap_pc   = r_trap_pc;

`ifdef SIM_MON_HIST_EN
   logic [XLEN-1:0] r_hist [HIST_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW:0]     r_hist_count;
   logic [XLEN-1:0] r_hist_rd_pc;
   logic [AW+2:0]   w_cnt_sum;

   assign w_cnt_sum = {2'b00, r_hist_count} + (AW+3)'(w_ncnt);

   // Storage is not reset; only entries below hist_count are meaningful.
   always_ff @(posedge i_clk) begin
      if (!i_rst && r_state == S_RUN) begin
         for (int i = 0; i < NCOMMIT; i++)
            if (w_cnt_lane[i])
               r_hist[r_wr_ptr + w_rank[i]] <= i_commit_pc[i*XLEN +: XLEN];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr     <= '0;
         r_hist_count <= '0;
         r_hist_rd_pc <= '0;
      end else begin
         r_hist_rd_pc <= r_hist[r_wr_ptr - AW'(1) - i_hist_rd_idx];
         if (r_state != S_RUN && i_start) begin
            r_hist_count <= '0;
         end else if (r_state == S_RUN) begin
            r_wr_ptr     <= r_wr_ptr + AW'(w_ncnt);
            r_hist_count <= (w_cnt_sum > (AW+3)'(HIST_DEPTH)) ? (AW+1)'(HIST_DEPTH)
                                                              : w_cnt_sum[AW:0];
         end
      end
   end

   assign o_hist_rd_pc = r_hist_rd_pc;
   assign o_hist_count = r_hist_count;
`else
   logic w_unused;
   assign w_unused     = ^{i_hist_rd_idx, w_cnt_lane, w_rank};
   assign o_hist_rd_pc = '0;
   assign o_hist_count = '0;
`endif

endmodule
